// File: rtl/npu_pkg.sv
// Types and default sizes shared by the NPU operand buffers.
package npu_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int INPUT_DEPTH  = 64;
    localparam int WEIGHT_DEPTH = 64;
    localparam int INDEX_DEPTH  = 32;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } fill_state_t;

    typedef enum logic [1:0] {
        BUF_INPUT  = 2'd0,
        BUF_WEIGHT = 2'd1,
        BUF_INDEX  = 2'd2
    } buf_kind_t;

    function automatic int buf_depth(buf_kind_t kind);
        case (kind)
            BUF_WEIGHT: return WEIGHT_DEPTH;
            BUF_INDEX:  return INDEX_DEPTH;
            default:    return INPUT_DEPTH;
        endcase
    endfunction

endpackage

// File: rtl/fill_buffer_if.sv
// Bus between one fill_buffer and its AXI front end / PE-array controller.
interface fill_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
);
    // Handshake: wr_en, rd_en and release_buf are sampled every rising edge with no
    // backpressure; buffer_ready is a level meaning FULL; rd_valid is a one-cycle
    // strobe qualifying rd_data the cycle after an rd_en accepted while FULL.
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              buffer_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              release_buf;
    logic [ADDR_W:0]   fill_count;
    logic              overflow_err;
    logic              addr_err;

    modport master (
        output wr_data, wr_en, rd_en, rd_addr, release_buf,
        input  buffer_ready, rd_data, rd_valid, fill_count, overflow_err, addr_err
    );

    modport slave (
        input  wr_data, wr_en, rd_en, rd_addr, release_buf,
        output buffer_ready, rd_data, rd_valid, fill_count, overflow_err, addr_err
    );

endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module sdp_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read register only loads on re so the last word is held between reads.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fill_buffer.sv
// Fill-then-drain operand store: sequential fill until FULL, random-access reads
// while FULL, emptied by release_buf.
module fill_buffer
    import npu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = INPUT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    fill_buffer_if.slave bus,
    output fill_state_t dbg_state
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    fill_state_t     state_q, state_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            ready_q, ready_d;
    logic            ovf_q, ovf_d;
    logic            rd_valid_q, rd_valid_d;
    logic            addr_err_q, addr_err_d;
    logic            rd_zero_q, rd_zero_d;
    logic            wr_fire;
    logic            rd_fire;
    logic            rd_in_range;
    logic            ram_re;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        wr_fire     = 1'b0;
        rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_C);
        rd_fire     = bus.rd_en && (state_q == FULL);
        rd_valid_d  = rd_fire;
        addr_err_d  = rd_fire && !rd_in_range;
        rd_zero_d   = rd_fire ? !rd_in_range : rd_zero_q;

        case (state_q)
            EMPTY, FILLING: begin
                if (bus.wr_en) begin
                    wr_fire = 1'b1;
                    count_d = count_q + 1'b1;
                    state_d = (count_d == DEPTH_C) ? FULL : FILLING;
                end
            end
            FULL: begin
                // A write coinciding with release is the tail of the old tile, not an overflow.
                if (bus.release_buf) begin
                    state_d = EMPTY;
                    count_d = '0;
                end else if (bus.wr_en) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase

        ready_d = (state_d == FULL);

        if (reset) begin
            state_d    = EMPTY;
            count_d    = '0;
            ovf_d      = 1'b0;
            ready_d    = 1'b0;
            rd_valid_d = 1'b0;
            addr_err_d = 1'b0;
            rd_zero_d  = 1'b1;
            wr_fire    = 1'b0;
            rd_fire    = 1'b0;
        end

        ram_re = rd_fire && rd_in_range;
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        count_q    <= count_d;
        ready_q    <= ready_d;
        ovf_q      <= ovf_d;
        rd_valid_q <= rd_valid_d;
        addr_err_q <= addr_err_d;
        rd_zero_q  <= rd_zero_d;
    end

    sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (count_q[ADDR_W-1:0]),
        .wdata (bus.wr_data),
        .re    (ram_re),
        .raddr (bus.rd_addr),
        .rdata (ram_rdata)
    );

    // rd_zero_q forces zero after reset and after an out-of-range read.
    assign bus.rd_data      = rd_zero_q ? '0 : ram_rdata;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.buffer_ready = ready_q;
    assign bus.fill_count   = count_q;
    assign bus.overflow_err = ovf_q;
    assign bus.addr_err     = addr_err_q;
    assign dbg_state        = state_q;

endmodule
